// File: rtl/inst_rom_responder_pkg.sv
// ----------------------------------------------------------------------------
// inst_rom_responder_pkg
//   Shared types, FSM state encodings and the built-in ROM image used by the
//   instruction-fetch responder and its word array.
//   No ports (package).
// ----------------------------------------------------------------------------
package inst_rom_responder_pkg;

    typedef logic [31:0] word_t;

    localparam word_t ZERO_WORD = 32'h0000_0000;

    // FSM encodings kept as plain constants so legacy code can compare against them
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Contents of the instruction ROM, one word per index. The low byte of the
    // index shows up in two byte lanes so every location is distinguishable,
    // and upper index bits fold into the top lanes so deep locations differ too.
    function automatic word_t romImageWord(input word_t idx);
        return 32'h2400_0000
             ^ {8'h00, idx[7:0], 8'h00, idx[7:0]}
             ^ {idx[31:8], 8'h00};
    endfunction

endpackage

// File: rtl/inst_rom_array.sv
// ----------------------------------------------------------------------------
// inst_rom_array
//   Read-only instruction word array with an asynchronous read port. The
//   image is fixed at elaboration by romImageWord and is never written.
// Ports:
//   index_i  in   DEPTH_LOG2  word index into the array
//   data_o   out  32          word stored at index_i
// ----------------------------------------------------------------------------
module inst_rom_array
    import inst_rom_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 17
) (
    input  logic [DEPTH_LOG2-1:0] index_i,
    output word_t                 data_o
);

    // Asynchronous read: the word follows the index within the same cycle
    assign data_o = romImageWord(word_t'(index_i));

endmodule

// File: rtl/inst_rom_responder.sv
// ----------------------------------------------------------------------------
// inst_rom_responder
//   Memory side of the OpenMIPS instruction-fetch interface. Accepts a fetch
//   request, optionally inserts WAIT_CYCLES access cycles, then presents the
//   instruction word while the CPU holds the same address. Requests a stall
//   whenever the CPU is fetching and the word is not yet valid.
// Ports:
//   clk           in   1   system clock
//   rst           in   1   asynchronous active-high reset
//   ce_i          in   1   fetch request enable
//   addr_i        in   32  byte address of the instruction
//   inst_o        out  32  instruction word, zero when not valid
//   inst_valid_o  out  1   inst_o belongs to the current addr_i
//   stall_req_o   out  1   CPU must hold PC and addr_i this cycle
//   err_o         out  1   sticky flag: misaligned or out-of-range fetch seen
// ----------------------------------------------------------------------------
module inst_rom_responder
    import inst_rom_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 17,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stall_req_o,
    output logic        err_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]  state_q,   state_d;
    word_t       latAddr_q, latAddr_d;
    logic [3:0]  waitCnt_q, waitCnt_d;
    logic        latBad_q,  latBad_d;
    logic        err_q,     err_d;

    logic        addrBad;
    logic        sameAddr;
    logic        relatch;
    logic        hit;
    word_t       romWord;

    // A fetch is bad if it is not word aligned or falls beyond the ROM depth
    assign addrBad  = (addr_i[1:0] != 2'b00) || (addr_i[31:DEPTH_LOG2+2] != '0);
    assign sameAddr = (addr_i == latAddr_q);

    // Data is only offered for the exact address that was latched; rst forces
    // all handshake outputs low even if the CPU keeps ce_i asserted
    assign hit = !rst && (state_q == ST_DATA) && ce_i && sameAddr;

    inst_rom_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_romArray (
        .index_i (latAddr_q[DEPTH_LOG2+1:2]),
        .data_o  (romWord)
    );

    // Next-state logic. Any address change while busy or presenting data
    // restarts the access for the new address, so a stale word is never
    // returned for an address the CPU has moved away from.
    always_comb begin
        state_d   = state_q;
        latAddr_d = latAddr_q;
        waitCnt_d = waitCnt_q;
        latBad_d  = latBad_q;
        err_d     = err_q;
        relatch   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ce_i) begin
                    relatch = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!ce_i) begin
                    state_d = ST_IDLE;
                end else if (!sameAddr) begin
                    relatch = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                    if (waitCnt_q == 4'd1) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (!ce_i) begin
                    state_d = ST_IDLE;
                end else if (!sameAddr) begin
                    relatch = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (relatch) begin
            latAddr_d = addr_i;
            latBad_d  = addrBad;
            waitCnt_d = WAIT_LOAD;
            err_d     = err_q | addrBad;
            state_d   = (WAIT_CYCLES == 0) ? ST_DATA : ST_WAIT;
        end
    end

    // State registers; reset drops any access in flight and clears the error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            latAddr_q <= ZERO_WORD;
            waitCnt_q <= 4'd0;
            latBad_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            latAddr_q <= latAddr_d;
            waitCnt_q <= waitCnt_d;
            latBad_q  <= latBad_d;
            err_q     <= err_d;
        end
    end

    // A bad fetch still completes its handshake but returns a nop
    assign inst_valid_o = hit;
    assign inst_o       = (hit && !latBad_q) ? romWord : ZERO_WORD;
    assign stall_req_o  = !rst && ce_i && !hit;
    assign err_o        = err_q;

endmodule

// File: tb/tb_inst_rom_responder.sv
// ----------------------------------------------------------------------------
// tb_inst_rom_responder
//   Directed bench for the instruction-fetch responder. Two instances share
//   clock and reset: one with no wait states and one with three.
// ----------------------------------------------------------------------------
module tb_inst_rom_responder;

    logic        clk;
    logic        rst;

    logic        ce0;
    logic [31:0] addr0;
    logic [31:0] inst0;
    logic        valid0;
    logic        stall0;
    logic        err0;

    logic        ce3;
    logic [31:0] addr3;
    logic [31:0] inst3;
    logic        valid3;
    logic        stall3;
    logic        err3;

    int          testsRun    = 0;
    int          testsFailed = 0;
    int          n;

    // Hand-computed image words for indices 0..3
    logic [31:0] image [4] = '{32'h2400_0000, 32'h2401_0001, 32'h2402_0002, 32'h2403_0003};

    inst_rom_responder #(
        .DEPTH_LOG2  (17),
        .WAIT_CYCLES (0)
    ) u_dutW0 (
        .clk          (clk),
        .rst          (rst),
        .ce_i         (ce0),
        .addr_i       (addr0),
        .inst_o       (inst0),
        .inst_valid_o (valid0),
        .stall_req_o  (stall0),
        .err_o        (err0)
    );

    inst_rom_responder #(
        .DEPTH_LOG2  (17),
        .WAIT_CYCLES (3)
    ) u_dutW3 (
        .clk          (clk),
        .rst          (rst),
        .ce_i         (ce3),
        .addr_i       (addr3),
        .inst_o       (inst3),
        .inst_valid_o (valid3),
        .stall_req_o  (stall3),
        .err_o        (err3)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and log any difference
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one instance's request inputs shortly after a clock edge, then let
    // the combinational outputs settle before anything is sampled
    task automatic applyStimulus(input bit useW3, input logic ce, input logic [31:0] addr);
        if (useW3) begin
            ce3   = ce;
            addr3 = addr;
        end else begin
            ce0   = ce;
            addr0 = addr;
        end
        #1;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case something upstream wedges the stimulus sequence
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        ce0   = 1'b0;
        addr0 = 32'h0;
        ce3   = 1'b0;
        addr3 = 32'h0;

        // Outputs stay quiet under reset even with a request present
        #50;
        applyStimulus(0, 1'b1, 32'h0);
        checkOutput("rstStall", {31'b0, stall0}, 32'd0);
        checkOutput("rstValid", {31'b0, valid0}, 32'd0);
        checkOutput("rstInst", inst0, 32'h0);
        checkOutput("rstErr", {31'b0, err0}, 32'd0);
        applyStimulus(0, 1'b0, 32'h0);
        #143;
        rst = 1'b0;
        tick();

        // Zero wait states: one stall cycle, then the word, held while addr is stable
        applyStimulus(0, 1'b1, 32'h0);
        checkOutput("t1Stall", {31'b0, stall0}, 32'd1);
        checkOutput("t1NotYet", {31'b0, valid0}, 32'd0);
        tick();
        checkOutput("t1Valid", {31'b0, valid0}, 32'd1);
        checkOutput("t1Inst", inst0, image[0]);
        checkOutput("t1StallOff", {31'b0, stall0}, 32'd0);
        tick();
        checkOutput("t1Hold", inst0, image[0]);

        // Dropping ce_i silences every output even while in the data state
        applyStimulus(0, 1'b0, 32'h0);
        checkOutput("ceOffStall", {31'b0, stall0}, 32'd0);
        checkOutput("ceOffValid", {31'b0, valid0}, 32'd0);
        checkOutput("ceOffInst", inst0, 32'h0);
        tick();

        // Sequential fetch, PC advancing only after each valid word
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1'b1, 32'(k * 4));
            n = 0;
            while (valid0 !== 1'b1 && n < 8) begin
                tick();
                n++;
            end
            checkOutput("seqLat", n, 32'd1);
            checkOutput("seqInst", inst0, image[k]);
            tick();
        end
        applyStimulus(0, 1'b0, 32'h0);
        tick();

        // Three wait states: four stall cycles then the word
        applyStimulus(1, 1'b1, 32'h4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("w3Stall", {31'b0, stall3}, 32'd1);
            checkOutput("w3NotYet", {31'b0, valid3}, 32'd0);
            tick();
        end
        checkOutput("w3Valid", {31'b0, valid3}, 32'd1);
        checkOutput("w3Inst", inst3, image[1]);
        checkOutput("w3StallOff", {31'b0, stall3}, 32'd0);
        applyStimulus(1, 1'b0, 32'h4);
        tick();

        // Address change in the second wait cycle restarts the access
        applyStimulus(1, 1'b1, 32'h8);
        tick();
        tick();
        applyStimulus(1, 1'b1, 32'hC);
        checkOutput("restartNotYet", {31'b0, valid3}, 32'd0);
        n = 0;
        while (valid3 !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        checkOutput("restartLat", n, 32'd4);
        checkOutput("restartInst", inst3, image[3]);
        applyStimulus(1, 1'b0, 32'h0);
        tick();

        // Misaligned and out-of-range fetches complete with a nop and set err_o
        checkOutput("errClean", {31'b0, err0}, 32'd0);
        applyStimulus(0, 1'b1, 32'h2);
        tick();
        checkOutput("misValid", {31'b0, valid0}, 32'd1);
        checkOutput("misInst", inst0, 32'h0);
        checkOutput("misErr", {31'b0, err0}, 32'd1);
        applyStimulus(0, 1'b1, 32'h0008_0000);
        checkOutput("rangeStall", {31'b0, stall0}, 32'd1);
        tick();
        checkOutput("rangeValid", {31'b0, valid0}, 32'd1);
        checkOutput("rangeInst", inst0, 32'h0);
        applyStimulus(0, 1'b0, 32'h0);
        tick();
        applyStimulus(0, 1'b1, 32'h0);
        tick();
        checkOutput("errSticky", {31'b0, err0}, 32'd1);
        checkOutput("postErrInst", inst0, image[0]);
        applyStimulus(0, 1'b0, 32'h0);
        tick();

        // Reset in the middle of a wait drops the access immediately
        applyStimulus(1, 1'b1, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("midRstStall", {31'b0, stall3}, 32'd0);
        checkOutput("midRstValid", {31'b0, valid3}, 32'd0);
        checkOutput("midRstInst", inst3, 32'h0);
        checkOutput("midRstErr", {31'b0, err0}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("relStall", {31'b0, stall3}, 32'd1);
        n = 0;
        while (valid3 !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        checkOutput("relLat", n, 32'd4);
        checkOutput("relInst", inst3, image[0]);
        checkOutput("w3ErrClean", {31'b0, err3}, 32'd0);
        applyStimulus(1, 1'b0, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
